// File: rtl/music_pkg.sv
// Shared types and constants for the note-code to square-wave generator.
`timescale 1ns/1ps
package music_pkg;

  localparam int unsigned OCT_W     = 3;
  localparam int unsigned NOTE_W    = 4;
  localparam int unsigned HALF_W    = 20;
  localparam int unsigned NUM_NOTES = 12;
  localparam logic [7:0]  END_CODE  = 8'hFF;

  typedef enum logic [1:0] {
    SILENT = 2'd0,
    GAP    = 2'd1,
    PLAY   = 2'd2
  } state_t;

  // Octave-0 half periods (C1..B1) in 50 MHz clocks.
  localparam logic [HALF_W-1:0] BASE [NUM_NOTES] = '{
    20'd764451, 20'd721541, 20'd681048, 20'd642824,
    20'd606747, 20'd572691, 20'd540552, 20'd510210,
    20'd481574, 20'd454545, 20'd429033, 20'd404954
  };

endpackage

// File: rtl/note_period_lut.sv
// Maps note/octave to the tone half period; flags note indices beyond B.
`timescale 1ns/1ps
module note_period_lut
  import music_pkg::*;
(
  input  logic [NOTE_W-1:0] note,
  input  logic [OCT_W-1:0]  octave,
  output logic [HALF_W-1:0] half,
  output logic              playable
);

  logic [HALF_W-1:0] base;

  always_comb begin
    base = '0;
    case (note)
      4'd0:    base = BASE[0];
      4'd1:    base = BASE[1];
      4'd2:    base = BASE[2];
      4'd3:    base = BASE[3];
      4'd4:    base = BASE[4];
      4'd5:    base = BASE[5];
      4'd6:    base = BASE[6];
      4'd7:    base = BASE[7];
      4'd8:    base = BASE[8];
      4'd9:    base = BASE[9];
      4'd10:   base = BASE[10];
      4'd11:   base = BASE[11];
      default: base = '0;
    endcase
    half     = base >> octave;
    playable = (note < NOTE_W'(NUM_NOTES));
  end

endmodule

// File: rtl/note_square_gen.sv
// Turns a streamed note code into a 50% square wave, with a silent gap on note changes.
`timescale 1ns/1ps
module note_square_gen
  import music_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 250000,
  parameter int unsigned CNT_W      = 20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] fullnote,
  output logic       speaker,
  output logic       active,
  output logic       note_start
);

  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic GAP_EN = (GAP_CYCLES != 0);

  state_t            state;
  logic [7:0]        note_q;
  logic              chg_q;
  logic              armed_q;
  logic [GAP_W-1:0]  gap_cnt;
  logic [CNT_W-1:0]  cnt;
  logic [HALF_W-1:0] half;
  logic              note_ok;
  logic              playable;
  logic [CNT_W-1:0]  limit;

  note_period_lut u_lut (
    .note     (note_q[3:0]),
    .octave   (note_q[6:4]),
    .half     (half),
    .playable (note_ok)
  );

  assign playable = ~note_q[7] & note_ok;
  assign limit    = CNT_W'(half - HALF_W'(1));

  // armed_q masks the stale code seen on the first edge after reset, so a tone needs a fresh change.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= SILENT;
      note_q     <= END_CODE;
      chg_q      <= 1'b0;
      armed_q    <= 1'b0;
      gap_cnt    <= '0;
      cnt        <= '0;
      speaker    <= 1'b0;
      active     <= 1'b0;
      note_start <= 1'b0;
    end else if (!enable) begin
      state      <= SILENT;
      note_q     <= END_CODE;
      chg_q      <= 1'b0;
      armed_q    <= 1'b1;
      gap_cnt    <= '0;
      cnt        <= '0;
      speaker    <= 1'b0;
      active     <= 1'b0;
      note_start <= 1'b0;
    end else begin
      note_q     <= fullnote;
      chg_q      <= armed_q && (fullnote != note_q);
      armed_q    <= 1'b1;
      note_start <= 1'b0;
      if (!playable) begin
        state   <= SILENT;
        gap_cnt <= '0;
        cnt     <= '0;
        speaker <= 1'b0;
        active  <= 1'b0;
      end else if (chg_q && GAP_EN) begin
        state   <= GAP;
        gap_cnt <= '0;
        cnt     <= '0;
        speaker <= 1'b0;
        active  <= 1'b0;
      end else if (chg_q || (state == GAP && gap_cnt == GAP_LAST)) begin
        state      <= PLAY;
        gap_cnt    <= '0;
        cnt        <= '0;
        speaker    <= 1'b1;
        active     <= 1'b1;
        note_start <= 1'b1;
      end else if (state == GAP) begin
        gap_cnt <= gap_cnt + GAP_W'(1);
      end else if (state == PLAY) begin
        if (cnt == limit) begin
          cnt     <= '0;
          speaker <= ~speaker;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: doc/note_square_gen.md
# note_square_gen

Converts the 8-bit note code streamed from the melody/bass note ROMs into a square-wave speaker drive. One instance sits directly downstream of each ROM in the music player and consumes its `fullnote` output. It decodes octave and note, then generates the tone with a reloadable half-period counter. It inserts a short silent gap on each note change so consecutive notes articulate, and decodes rests and end-of-song as silence.

## Interface
- `GAP_CYCLES`, default 250000: silent cycles inserted on each change to a new playable note (5 ms at 50 MHz); 0 disables the gap.
- `CNT_W`, default 20: width of the half-period counter; must hold 764451.
- `clock` in 1: system clock, 50 MHz.
- `reset` in 1: asynchronous, active-low reset.
- `enable` in 1: when low, the block is held silent and its state cleared.
- `fullnote` in 8: note code from the ROM.
  - [7] = 0 for a note.
  - [6:4] = octave 0..7.
  - [3:0] = note 0..11 (C..B).
  - 8'hFF = end marker.
  - Any code with [7]=1 or [3:0]>11 is a rest.
- `speaker` out 1: square-wave drive.
- `active` out 1: high while in PLAY.
- `note_start` out 1: one-cycle pulse on entry to PLAY.

## Operation
- **Input register.** `fullnote` is registered every cycle into `note_q`. Change detection compares `fullnote` against `note_q`.
- **Half-period.**
  - half = BASE[note] >> octave, truncated; counter limit = half − 1.
  - BASE (50 MHz, octave 0 = C1..B1): 764451, 721541, 681048, 642824, 606747, 572691, 540552, 510210, 481574, 454545, 429033, 404954.
- **States.** SILENT, GAP, PLAY.
- **SILENT**
  - `speaker` = 0, counter = 0.
  - A playable `note_q` moves to GAP, or directly to PLAY if GAP_CYCLES = 0.
- **GAP**
  - `speaker` = 0; the gap counter counts to GAP_CYCLES − 1, then the state moves to PLAY.
  - A further note change during GAP restarts the gap count.
  - A rest during GAP moves to SILENT.
- **PLAY**
  - On entry: counter = 0, `speaker` = 1, `note_start` = 1 for one cycle.
  - When the counter reaches the limit, `speaker` toggles and the counter clears.
- **Note change to another playable note.**
  - Moves to GAP, or restarts PLAY (counter 0, `speaker` 1, new `note_start` pulse) if GAP_CYCLES = 0.
  - The same code repeated (unchanged `note_q`) continues the waveform without interruption.
- **Rest / 8'hFF.** From any state, the next cycle is SILENT and `speaker` = 0.
- **`enable` low.** Synchronous clear: state SILENT, all counters 0, `speaker` 0, `note_q` 8'hFF.

## Timing
- **Reset values:**
  - state SILENT; `speaker` 0, `active` 0, `note_start` 0.
  - `note_q` 8'hFF; counters 0.
- **Latency, `fullnote` change to the first `speaker` rise:**
  - GAP_CYCLES = 0: 2 clocks (register, then state update).
  - Otherwise: 2 + GAP_CYCLES clocks.
- **`active` timing.** `active` rises in the same cycle as `note_start` and falls in the cycle `speaker` is forced low.
- **Waveform.**
  - Each high phase and each low phase lasts exactly `half` clocks.
  - Period = 2·half, duty 50 %.
  - For octave 7, the minimum half is 404954>>7 = 3163, so no period underflow is possible.
- **Simultaneous events.** `enable` low beats a note change, which beats a counter toggle. A toggle pending in the same cycle as a note change is discarded.
- **Asynchronous reset mid-tone.** `speaker` drops immediately. After release, the first tone waits for a fresh note change.

## Structure
- Package `music_pkg` holds:
  - the BASE[0:11] constant table;
  - the state enum {SILENT, GAP, PLAY};
  - the field widths (octave 3, note 4, counter 20);
  - the END code 8'hFF.
- Sub-module `note_period_lut` (combinational): note[3:0], octave[2:0] → half[19:0], plus a `playable` flag.
- Top module: input register, FSM, gap counter, half-period counter, output flops.

## Test plan
- **Reset.** Assert `reset` low mid-tone → `speaker`/`active` go 0 asynchronously. After release with `fullnote` = 8'h29, stay silent until `fullnote` changes.
- **A at octave 2, GAP_CYCLES = 0.**
  - Stimulus: `fullnote` 8'hFF → 8'h29.
  - Response: `note_start` pulse 2 clocks later; `speaker` high 113636 clocks, then low 113636 clocks, repeating.
- **Gap.**
  - Stimulus: GAP_CYCLES = 1000; change 8'h29 → 8'h20.
  - Response: `speaker` 0 for 1000 clocks, then high for 764451>>2 = 191112 clocks.
- **Rest/end.** Code 8'h0C, 8'h8F or 8'hFF during PLAY → `speaker` 0 and `active` 0 the next cycle; no `note_start`.
- **Repeat.** Hold 8'h75 (octave 7, F) for 100000 clocks → continuous period 2·4474; a single `note_start`.
- **Enable.** Drop `enable` mid-GAP → SILENT the next cycle. Raise `enable` with the same note → a new gap, then a `note_start` pulse.
